// File: rtl/hweval_montgomery_seq.sv
// On-chip evaluation sequencer: runs ITER chained multiplications on an attached
// Montgomery multiplier, folds results into a signature and tracks latency/timeouts.
module hweval_montgomery_seq #(
    parameter int               WIDTH   = 1024,
    parameter int               ITER    = 16,
    parameter int               TIMEOUT = 4096,
    parameter int               CW      = 16,
    parameter logic [WIDTH-1:0] M_INIT  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [1:0]       mode,
    output logic             dut_start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic [WIDTH-1:0] dut_m,
    input  logic             dut_done,
    input  logic [WIDTH-1:0] dut_result,
    output logic             busy,
    output logic             finished,
    output logic             timeout_err,
    output logic [CW-1:0]    iter_cnt,
    output logic [CW-1:0]    max_lat,
    output logic [WIDTH-1:0] signature,
    output logic             data_ok,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_FEED  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [CW-1:0]    TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0]    ITER_C    = CW'(ITER);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state;
    logic [CW-1:0]    lat_cnt;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    iter_next;

    assign iter_next = iter_cnt + CW'(1);

    // Multiplier handshake: dut_start is a single-cycle request carrying dut_a/b/m;
    // dut_done is a single-cycle response with dut_result, honoured only in S_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            dut_start   <= 1'b0;
            dut_a       <= ONE;
            dut_b       <= ONE;
            dut_m       <= M_INIT;
            busy        <= 1'b0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
            iter_cnt    <= '0;
            max_lat     <= '0;
            signature   <= '0;
            lat_cnt     <= '0;
            mode_q      <= 2'd0;
            res_q       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        dut_a       <= ONE;
                        dut_b       <= ONE;
                        dut_m       <= M_INIT;
                        iter_cnt    <= '0;
                        max_lat     <= '0;
                        signature   <= '0;
                        finished    <= 1'b0;
                        timeout_err <= 1'b0;
                        mode_q      <= mode;
                        dut_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    dut_start <= 1'b0;
                    lat_cnt   <= CW'(1);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done on the timeout cycle still wins over the error.
                    if (dut_done) begin
                        if (lat_cnt > max_lat) begin
                            max_lat <= lat_cnt;
                        end
                        res_q <= dut_result;
                        state <= S_FEED;
                    end else if (lat_cnt == TIMEOUT_C) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_ERR;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                S_FEED: begin
                    case (mode_q)
                        2'd0: begin
                            dut_a <= dut_b ^ res_q;
                            dut_b <= res_q;
                        end
                        2'd1: begin
                            dut_a <= res_q;
                            dut_b <= res_q;
                        end
                        2'd2: begin
                            dut_a <= res_q;
                        end
                        default: begin
                            dut_a <= dut_b;
                            dut_b <= res_q;
                        end
                    endcase
                    signature <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ res_q;
                    iter_cnt  <= iter_next;
                    if (iter_next == ITER_C) begin
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        dut_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_ok   = finished & ~timeout_err & signature[WIDTH-1];
    assign state_dbg = state;

endmodule

// File: tb/tb_hweval_montgomery_seq.sv
// Directed bench for hweval_montgomery_seq with a stub multiplier of configurable
// latency and result function; expected values are worked out by hand.
module tb_hweval_montgomery_seq;

    localparam int W = 8;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_DONE = 3'd4, ST_ERR = 3'd5;

    logic         clk = 1'b0;
    logic         reset, go, inj_done;
    logic [1:0]   mode;
    logic         dut_start, dut_done, busy, finished, timeout_err, data_ok;
    logic [W-1:0] dut_a, dut_b, dut_m, dut_result, signature;
    logic [7:0]   iter_cnt, max_lat;
    logic [2:0]   state_dbg;

    hweval_montgomery_seq #(
        .WIDTH(8), .ITER(3), .TIMEOUT(10), .CW(8), .M_INIT(8'hC5)
    ) u_dut (
        .clk(clk), .reset(reset), .go(go), .mode(mode),
        .dut_start(dut_start), .dut_a(dut_a), .dut_b(dut_b), .dut_m(dut_m),
        .dut_done(dut_done), .dut_result(dut_result),
        .busy(busy), .finished(finished), .timeout_err(timeout_err),
        .iter_cnt(iter_cnt), .max_lat(max_lat), .signature(signature),
        .data_ok(data_ok), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stub multiplier ----------------
    int           stub_lat = 4;   // 0 = never answers
    int           stub_fn  = 0;   // 0: a+b, 1: a*a mod 251, 2: a^b^0x80
    int           rem = 0;
    logic         stub_done = 1'b0;
    logic [W-1:0] stub_res = '0, pa = '0, pb = '0;

    function automatic logic [W-1:0] stub_eval(input int fn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [15:0] sq;
        case (fn)
            0: return a + b;
            1: begin
                sq = 16'(a) * 16'(a);
                return 8'(sq % 16'd251);
            end
            default: return a ^ b ^ 8'h80;
        endcase
    endfunction

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (dut_start) begin
            if (stub_lat == 1) begin
                stub_done <= 1'b1;
                stub_res  <= stub_eval(stub_fn, dut_a, dut_b);
            end else if (stub_lat > 1) begin
                rem <= stub_lat - 1;
                pa  <= dut_a;
                pb  <= dut_b;
            end
        end else if (rem > 0) begin
            if (rem == 1) begin
                stub_done <= 1'b1;
                stub_res  <= stub_eval(stub_fn, pa, pb);
            end
            rem <= rem - 1;
        end
    end

    assign dut_done   = stub_done | inj_done;
    assign dut_result = stub_res;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W-1:0] exp_q[$];
    int start_cyc_q[$];
    int start_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (dut_start) begin
            start_cnt++;
            start_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                check("operands_ab", {16'd0, dut_a, dut_b}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_go(input logic [1:0] m);
        @(negedge clk);
        go   = 1'b1;
        mode = m;
        @(negedge clk);
        go   = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        int n = 0;
        while (!(finished || timeout_err) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("run_ends_in_budget", {31'd0, finished | timeout_err}, 32'd1);
    endtask

    task automatic wait_starts(input int count, input int max_cyc);
        int seen = 0;
        int n = 0;
        while (seen < count && n < max_cyc) begin
            @(negedge clk);
            if (dut_start) seen++;
            n++;
        end
        check("starts_in_budget", seen, count);
    endtask

    task automatic check_reset_vals();
        check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("rst_dut_start", {31'd0, dut_start}, 32'd0);
        check("rst_dut_a", {24'd0, dut_a}, 32'd1);
        check("rst_dut_b", {24'd0, dut_b}, 32'd1);
        check("rst_dut_m", {24'd0, dut_m}, 32'h0000_00C5);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_finished", {31'd0, finished}, 32'd0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        check("rst_iter", {24'd0, iter_cnt}, 32'd0);
        check("rst_max_lat", {24'd0, max_lat}, 32'd0);
        check("rst_sig", {24'd0, signature}, 32'd0);
        check("rst_data_ok", {31'd0, data_ok}, 32'd0);
    endtask

    task automatic check_run(input string tag, input logic [7:0] sig, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] lat, input logic ok);
        check({tag, "_finished"}, {31'd0, finished}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
        check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_DONE});
        check({tag, "_iter"}, {24'd0, iter_cnt}, 32'd3);
        check({tag, "_sig"}, {24'd0, signature}, {24'd0, sig});
        check({tag, "_a"}, {24'd0, dut_a}, {24'd0, a});
        check({tag, "_b"}, {24'd0, dut_b}, {24'd0, b});
        check({tag, "_m"}, {24'd0, dut_m}, 32'h0000_00C5);
        check({tag, "_max_lat"}, {24'd0, max_lat}, {24'd0, lat});
        check({tag, "_data_ok"}, {31'd0, data_ok}, {31'd0, ok});
    endtask

    // ---------------- directed sequence ----------------
    int base;
    initial begin
        reset = 1'b1; go = 1'b0; mode = 2'd0; inj_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals();

        // mode 0, a+b, latency 4: R = 2, 5, 12
        stub_lat = 4; stub_fn = 0;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0302); exp_q.push_back(16'h0705);
        start_cyc_q.delete();
        pulse_go(2'd0);
        wait_end(100);
        check_run("m0", 8'h0E, 8'h09, 8'h0C, 8'd4, 1'b0);
        check("m0_start_count", start_cyc_q.size(), 32'd3);
        if (start_cyc_q.size() == 3) begin
            check("m0_gap1", start_cyc_q[1] - start_cyc_q[0], 32'd6);
            check("m0_gap2", start_cyc_q[2] - start_cyc_q[1], 32'd6);
        end

        // stub never answers: error after the 10th WAIT cycle
        stub_lat = 0;
        exp_q.push_back(16'h0101);
        pulse_go(2'd0);
        repeat (10) @(negedge clk);
        check("to_pre_state", {29'd0, state_dbg}, {29'd0, ST_WAIT});
        check("to_pre_err", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_state", {29'd0, state_dbg}, {29'd0, ST_ERR});
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_data_ok", {31'd0, data_ok}, 32'd0);
        repeat (5) @(negedge clk);
        check("to_hold_err", {31'd0, timeout_err}, 32'd1);
        check("to_hold_state", {29'd0, state_dbg}, {29'd0, ST_ERR});

        // restart from ERR
        stub_lat = 4;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0302); exp_q.push_back(16'h0705);
        pulse_go(2'd0);
        check("rs_err_cleared", {31'd0, timeout_err}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd1);
        wait_end(100);
        check_run("rs", 8'h0E, 8'h09, 8'h0C, 8'd4, 1'b0);

        // done lands exactly on lat_cnt == TIMEOUT
        stub_lat = 10;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0302); exp_q.push_back(16'h0705);
        pulse_go(2'd0);
        wait_end(200);
        check_run("edge", 8'h0E, 8'h09, 8'h0C, 8'd10, 1'b0);

        // mode 1, a*a mod 251: operands stay (1,1)
        stub_lat = 3; stub_fn = 1;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0101); exp_q.push_back(16'h0101);
        pulse_go(2'd1);
        wait_end(100);
        check_run("m1", 8'h07, 8'h01, 8'h01, 8'd3, 1'b0);

        // mode 2, a^b^0x80: R = 80, 01, 80 -> signature 0x80
        stub_lat = 2; stub_fn = 2;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h8001); exp_q.push_back(16'h0101);
        pulse_go(2'd2);
        wait_end(100);
        check_run("m2", 8'h80, 8'h80, 8'h01, 8'd2, 1'b1);

        // mode 3, a+b: R = 2, 3, 5
        stub_lat = 5; stub_fn = 0;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0102); exp_q.push_back(16'h0203);
        pulse_go(2'd3);
        wait_end(100);
        check_run("m3", 8'h0B, 8'h03, 8'h05, 8'd5, 1'b0);

        // reset during WAIT of op 2; the pending done arrives later in IDLE
        stub_lat = 4;
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0302);
        pulse_go(2'd0);
        wait_starts(1, 20);
        repeat (2) @(negedge clk);
        check("rw_in_wait", {29'd0, state_dbg}, {29'd0, ST_WAIT});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals();
        base = start_cnt;
        repeat (10) @(negedge clk);
        check("rw_no_start", start_cnt - base, 32'd0);
        check("rw_late_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("rw_late_iter", {24'd0, iter_cnt}, 32'd0);
        check("rw_late_sig", {24'd0, signature}, 32'd0);
        check("rw_late_max", {24'd0, max_lat}, 32'd0);

        // spurious done in IDLE
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("idle_done_busy", {31'd0, busy}, 32'd0);

        // go while busy (mode 1 request) must not disturb a mode 0 run
        exp_q.push_back(16'h0101); exp_q.push_back(16'h0302); exp_q.push_back(16'h0705);
        pulse_go(2'd0);
        wait_starts(1, 20);
        pulse_go(2'd1);
        wait_end(100);
        check_run("gb", 8'h0E, 8'h09, 8'h0C, 8'd4, 1'b0);

        // spurious done in DONE
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        repeat (2) @(negedge clk);
        check_run("dd", 8'h0E, 8'h09, 8'h0C, 8'd4, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
